// File: rtl/cdc_pkg.sv
// Types and constants shared by both ends of the toggle req/ack clock-domain crossing.
package cdc_pkg;

  localparam int CDC_MIN_SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } cdc_send_state_t;

endpackage : cdc_pkg

// File: rtl/cdc_handshake_sender_if.sv
// Source-side bundle: valid/ready word intake, the req/data/ack crossing, and the error flag.
interface cdc_handshake_sender_if #(
  parameter int WIDTH = 32
);

  logic             send_valid;
  logic [WIDTH-1:0] send_data;
  logic             send_ready;
  logic             xfer_req;
  logic [WIDTH-1:0] xfer_data;
  logic             xfer_ack;
  logic             protocol_error;

  // The sender owns the crossing, so it takes the master view.
  modport master (
    input  send_valid,
    input  send_data,
    input  xfer_ack,
    output send_ready,
    output xfer_req,
    output xfer_data,
    output protocol_error
  );

  modport slave (
    output send_valid,
    output send_data,
    output xfer_ack,
    input  send_ready,
    input  xfer_req,
    input  xfer_data,
    input  protocol_error
  );

endinterface : cdc_handshake_sender_if

// File: rtl/cdc_handshake_sender.sv
// Source end of a two-phase req/ack crossing: latches a word, toggles xfer_req, and waits
// for the synchronized ack toggle before taking the next word.
module cdc_handshake_sender
  import cdc_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  cdc_handshake_sender_if.master bus
);

  if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : g_sync_stages_check
    $error("cdc_handshake_sender: SYNC_STAGES must be at least %0d", CDC_MIN_SYNC_STAGES);
  end

  cdc_send_state_t        r_state;
  cdc_send_state_t        w_state_nxt;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   r_ack_seen;
  logic                   r_xfer_req;
  logic [WIDTH-1:0]       r_xfer_data;
  logic                   r_protocol_error;
  logic                   w_ack_sync;
  logic                   w_ack_edge;
  logic                   w_ready;
  logic                   w_accept;

  assign w_ack_sync = r_ack_sync[SYNC_STAGES-1];
  assign w_ack_edge = w_ack_sync ^ r_ack_seen;
  assign w_ready    = (r_state == IDLE) && !reset;
  assign w_accept   = w_ready && bus.send_valid;

  // NOTE: the ack chain is cleared on reset so a stale level cannot surface as a phantom ack
  // edge afterwards; this only holds if the destination is reset in the same event.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack_sync <= '0;
      r_ack_seen <= 1'b0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.xfer_ack};
      r_ack_seen <= w_ack_sync;
    end
  end

  // NOTE: every clocked block uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: w_state_nxt gets its hold value first, so no path through the case leaves a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_accept)   w_state_nxt = WAIT_ACK;
      WAIT_ACK: if (w_ack_edge) w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // Data and req move on the same edge; the destination's req synchronizer gives data time to settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xfer_req       <= 1'b0;
      r_xfer_data      <= '0;
      r_protocol_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_xfer_req  <= ~r_xfer_req;
        r_xfer_data <= bus.send_data;
      end
      if (w_ack_edge && (r_state == IDLE)) begin
        r_protocol_error <= 1'b1;
      end
    end
  end

  assign bus.send_ready     = w_ready;
  assign bus.xfer_req       = r_xfer_req;
  assign bus.xfer_data      = r_xfer_data;
  assign bus.protocol_error = r_protocol_error;

endmodule : cdc_handshake_sender

// File: tb/tb_cdc_handshake_sender.sv
// Bench for cdc_handshake_sender: a driver queues each sent word, a monitor pops and checks it
// when xfer_req toggles, and a behavioural destination returns the ack toggle.
module tb_cdc_handshake_sender;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ack_auto = 1'b0;
  logic        ack_manual = 1'b0;
  bit          auto_ack_en = 1'b0;
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_toggles = 0;

  cdc_handshake_sender_if #(.WIDTH(32)) bus ();

  cdc_handshake_sender #(
    .WIDTH      (32),
    .SYNC_STAGES(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.xfer_ack = ack_auto ^ ack_manual;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Destination model: answers every req toggle with an ack toggle two cycles later.
  initial begin : auto_ack
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ack_auto = 1'b0;
        cnt      = 0;
      end else if (auto_ack_en && (bus.xfer_req !== bus.xfer_ack)) begin
        cnt++;
        if (cnt == 2) begin
          ack_auto = ~ack_auto;
          cnt      = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: each req toggle must carry the next queued word, held until the ack matches req.
  initial begin : monitor
    logic        prev_req;
    logic        pending;
    logic        stable;
    logic [31:0] cap;
    logic [31:0] want;
    prev_req = 1'b0;
    pending  = 1'b0;
    stable   = 1'b1;
    cap      = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = bus.xfer_req;
        pending  = 1'b0;
      end else begin
        if (bus.xfer_req !== prev_req) begin
          prev_req = bus.xfer_req;
          n_toggles++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_xfer: got word %h, expected no transfer (t=%0t)",
                     bus.xfer_data, $time);
          end else begin
            want = exp_q.pop_front();
            check("xfer_data", bus.xfer_data, want);
          end
          cap     = bus.xfer_data;
          pending = 1'b1;
          stable  = 1'b1;
        end
        if (pending) begin
          if (bus.xfer_data !== cap) stable = 1'b0;
          if (bus.xfer_ack === bus.xfer_req) begin
            check("data_hold", 32'(stable), 32'd1);
            pending = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send_word(input logic [31:0] w, input bit keep_valid);
    int n;
    n = 0;
    bus.send_valid = 1'b1;
    bus.send_data  = w;
    exp_q.push_back(w);
    while (!bus.send_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 32'(n < 100), 32'd1);
    @(negedge clk);
    if (!keep_valid) bus.send_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(bus.send_ready && (bus.xfer_req === bus.xfer_ack)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 100), 32'd1);
  endtask

  task automatic do_reset(input string name);
    reset      = 1'b1;
    ack_manual = 1'b0;
    @(negedge clk);
    check({name, "_ready_in_reset"}, 32'(bus.send_ready), 32'd0);
    check({name, "_req"}, 32'(bus.xfer_req), 32'd0);
    check({name, "_data"}, bus.xfer_data, 32'd0);
    check({name, "_err"}, 32'(bus.protocol_error), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check({name, "_ready_after"}, 32'(bus.send_ready), 32'd1);
    check({name, "_req_after"}, 32'(bus.xfer_req), 32'd0);
    check({name, "_err_after"}, 32'(bus.protocol_error), 32'd0);
  endtask

  initial begin : stimulus
    bus.send_valid = 1'b0;
    bus.send_data  = '0;
    do_reset("init");

    // Single transfer; ack sampled at edge N+4 gives ready again after edge N+7.
    send_word(32'hDEADBEEF, 1'b0);
    check("single_req", 32'(bus.xfer_req), 32'd1);
    check("single_data", bus.xfer_data, 32'hDEADBEEF);
    for (int k = 0; k <= 6; k++) begin
      check("single_ready_low", 32'(bus.send_ready), 32'd0);
      if (k == 3) ack_manual = 1'b1;
      @(negedge clk);
    end
    check("single_ready_high", 32'(bus.send_ready), 32'd1);

    // Data hold: new data offered with valid high throughout WAIT_ACK and on the release edge.
    send_word(32'hA5A55A5A, 1'b0);
    for (int k = 0; k <= 4; k++) begin
      check("hold_data", bus.xfer_data, 32'hA5A55A5A);
      check("hold_req", 32'(bus.xfer_req), 32'd0);
      check("hold_ready_low", 32'(bus.send_ready), 32'd0);
      bus.send_valid = 1'b1;
      bus.send_data  = $urandom;
      if (k == 1) ack_manual = ~ack_manual;
      @(negedge clk);
    end
    bus.send_valid = 1'b0;
    check("release_edge_not_taken", 32'(bus.xfer_req), 32'd0);
    check("release_ready_high", 32'(bus.send_ready), 32'd1);
    check("release_data", bus.xfer_data, 32'hA5A55A5A);

    // Back-to-back words 0..7 with valid held high and the destination auto-acking.
    auto_ack_en = 1'b1;
    n_toggles   = 0;
    for (int w = 0; w < 8; w++) send_word(32'(w), 1'b1);
    bus.send_valid = 1'b0;
    wait_idle("b2b_idle");
    check("b2b_toggles", 32'(n_toggles), 32'd8);
    check("b2b_final_req", 32'(bus.xfer_req), 32'd0);
    auto_ack_en = 1'b0;

    // Spurious ack while IDLE: error rises three edges later and sticks.
    check("spur_err_before", 32'(bus.protocol_error), 32'd0);
    ack_manual = ~ack_manual;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("spur_ready", 32'(bus.send_ready), 32'd1);
      check("spur_err", 32'(bus.protocol_error), (k >= 3) ? 32'd1 : 32'd0);
    end
    ack_manual = ~ack_manual;
    repeat (5) @(negedge clk);
    check("spur_err_sticky", 32'(bus.protocol_error), 32'd1);
    check("spur_ready_after", 32'(bus.send_ready), 32'd1);

    // Reset while a transfer is outstanding.
    send_word(32'h12345678, 1'b0);
    repeat (2) @(negedge clk);
    check("mid_req", 32'(bus.xfer_req), 32'd1);
    check("mid_ready_low", 32'(bus.send_ready), 32'd0);
    do_reset("mid_reset");

    auto_ack_en = 1'b1;
    send_word(32'hCAFEF00D, 1'b0);
    wait_idle("post_reset_idle");
    check("post_reset_req", 32'(bus.xfer_req), 32'd1);
    check("post_reset_data", bus.xfer_data, 32'hCAFEF00D);
    auto_ack_en = 1'b0;

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_cdc_handshake_sender
